// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and the state encoding used by
// both the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_W    = 8;
  localparam int FRAME_LEN = 10;
  localparam int STATE_W   = 3;

  localparam logic [STATE_W-1:0] IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] START   = 3'd1;
  localparam logic [STATE_W-1:0] DATA    = 3'd2;
  localparam logic [STATE_W-1:0] STOP    = 3'd3;
  localparam logic [STATE_W-1:0] CLEANUP = 3'd4;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO feeding the UART transmitter.
// Wrapping pointers plus an explicit occupancy count; full when count==DEPTH.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset_n,
  input  logic                         i_Push,
  input  logic [DATA_W-1:0]            i_Push_Data,
  input  logic                         i_Pop,
  output logic [DATA_W-1:0]            o_Head,
  output logic                         o_Full,
  output logic                         o_Empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_Mem [DEPTH];
  logic [PTR_W-1:0]  r_Wr_Ptr;
  logic [PTR_W-1:0]  r_Rd_Ptr;
  logic [CNT_W-1:0]  r_Count;
  logic              w_Push_Ok;
  logic              w_Pop_Ok;

  assign o_Full    = (r_Count == CNT_W'(DEPTH));
  assign o_Empty   = (r_Count == '0);
  assign o_Count   = r_Count;
  assign o_Head    = r_Mem[r_Rd_Ptr];
  assign w_Push_Ok = i_Push & ~o_Full;
  assign w_Pop_Ok  = i_Pop & ~o_Empty;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge i_Clock) begin
    if (w_Push_Ok) begin
      r_Mem[r_Wr_Ptr] <= i_Push_Data;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Wr_Ptr <= '0;
      r_Rd_Ptr <= '0;
      r_Count  <= '0;
    end else begin
      if (w_Push_Ok) r_Wr_Ptr <= r_Wr_Ptr + PTR_W'(1);
      if (w_Pop_Ok)  r_Rd_Ptr <= r_Rd_Ptr + PTR_W'(1);
      case ({w_Push_Ok, w_Pop_Ok})
        2'b10:   r_Count <= r_Count + CNT_W'(1);
        2'b01:   r_Count <= r_Count - CNT_W'(1);
        default: r_Count <= r_Count;
      endcase
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a small input FIFO. The line, active and done
// outputs are registered from the state, so they trail the FSM by one cycle.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             i_Clock,
  input  logic                             i_Reset_n,
  input  logic                             i_Tx_DV,
  input  logic [7:0]                       i_Tx_Byte,
  output logic                             o_Tx_Ready,
  output logic                             o_Tx_Serial,
  output logic                             o_Tx_Active,
  output logic                             o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_Fifo_Count
);

  localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

  logic [STATE_W-1:0] r_State;
  logic [15:0]        r_Clk_Count;
  logic [2:0]         r_Bit_Index;
  logic [7:0]         r_Shift;
  logic               r_Tx_Serial;
  logic               r_Tx_Active;
  logic               r_Tx_Done;
  logic [7:0]         w_Head;
  logic               w_Full;
  logic               w_Empty;
  logic               w_Pop;
  logic               w_Bit_End;
  logic               w_Line;

  uart_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock     (i_Clock),
    .i_Reset_n   (i_Reset_n),
    .i_Push      (i_Tx_DV),
    .i_Push_Data (i_Tx_Byte),
    .i_Pop       (w_Pop),
    .o_Head      (w_Head),
    .o_Full      (w_Full),
    .o_Empty     (w_Empty),
    .o_Count     (o_Fifo_Count)
  );

  assign o_Tx_Ready  = ~w_Full;
  assign o_Tx_Serial = r_Tx_Serial;
  assign o_Tx_Active = r_Tx_Active;
  assign o_Tx_Done   = r_Tx_Done;
  assign w_Pop       = (r_State == IDLE) & ~w_Empty;
  assign w_Bit_End   = (r_Clk_Count == LAST_CLK);

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_State     <= IDLE;
      r_Clk_Count <= '0;
      r_Bit_Index <= '0;
    end else begin
      case (r_State)
        IDLE: begin
          if (!w_Empty) begin
            r_State     <= START;
            r_Clk_Count <= '0;
            r_Bit_Index <= '0;
          end
        end
        START: begin
          if (w_Bit_End) begin
            r_Clk_Count <= '0;
            r_State     <= DATA;
          end else begin
            r_Clk_Count <= r_Clk_Count + 16'd1;
          end
        end
        DATA: begin
          if (w_Bit_End) begin
            r_Clk_Count <= '0;
            if (r_Bit_Index == 3'd7) begin
              r_Bit_Index <= '0;
              r_State     <= STOP;
            end else begin
              r_Bit_Index <= r_Bit_Index + 3'd1;
            end
          end else begin
            r_Clk_Count <= r_Clk_Count + 16'd1;
          end
        end
        STOP: begin
          if (w_Bit_End) begin
            r_Clk_Count <= '0;
            r_State     <= CLEANUP;
          end else begin
            r_Clk_Count <= r_Clk_Count + 16'd1;
          end
        end
        CLEANUP: r_State <= IDLE;
        default: begin
          r_State     <= IDLE;
          r_Clk_Count <= '0;
          r_Bit_Index <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (w_Pop) begin
      r_Shift <= w_Head;
    end
  end

  always_comb begin
    w_Line = 1'b1;
    case (r_State)
      START:   w_Line = 1'b0;
      DATA:    w_Line = r_Shift[r_Bit_Index];
      default: w_Line = 1'b1;
    endcase
  end

  // Output stage: line, active and done all share the same one-cycle lag.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Tx_Serial <= 1'b1;
      r_Tx_Active <= 1'b0;
      r_Tx_Done   <= 1'b0;
    end else begin
      r_Tx_Serial <= w_Line;
      r_Tx_Active <= (r_State == START) || (r_State == DATA) || (r_State == STOP);
      r_Tx_Done   <= (r_State == CLEANUP);
    end
  end

endmodule
